// File: rtl/mips_alu_seq_if.sv
// Request/response bundle for the sequential MIPS ALU.
// The master drives operands and start; the slave returns status and results.
interface mips_alu_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [3:0]   alu_ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] alu_out;
    logic [W-1:0] hi;
    logic         zero;
    logic         overflow;
    logic         div_zero;

    modport master (
        output start, alu_ctl, a, b,
        input  busy, done, alu_out, hi, zero, overflow, div_zero
    );

    modport slave (
        input  start, alu_ctl, a, b,
        output busy, done, alu_out, hi, zero, overflow, div_zero
    );
endinterface

// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU with iterative unsigned multiply and divide.
// Single-cycle ops complete in one edge; mult/div take W iteration cycles.
module mips_alu_seq #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_alu_seq_if.slave bus
);
    localparam int SHW = $clog2(W);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MULT = 4'b1010,
        OP_DIV  = 4'b1011,
        OP_NOR  = 4'b1100
    } op_e;

    typedef enum logic {IDLE, ITER} state_e;

    state_e         state_q;
    logic           is_div_q;
    logic [SHW-1:0] count_q;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   acc_hi_q;
    logic [W-1:0]   acc_lo_q;
    logic [W-1:0]   alu_out_q;
    logic [W-1:0]   hi_q;
    logic           ovf_q;
    logic           dz_q;
    logic           done_q;

    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [SHW-1:0] sh;
    logic [W-1:0]   res_d;
    logic           ovf_d;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    assign sh   = bus.b[SHW-1:0];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (bus.alu_ctl)
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_XOR:  res_d = bus.a ^ bus.b;
            OP_NOR:  res_d = ~(bus.a | bus.b);
            OP_ADD: begin
                res_d = sum;
                ovf_d = (bus.a[W-1] == bus.b[W-1]) &&
                        (sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (bus.a[W-1] != bus.b[W-1]) &&
                        (diff[W-1] != bus.a[W-1]);
            end
            OP_SLT:  res_d = {{(W-1){1'b0}},
                              ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: res_d = {{(W-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  res_d = bus.a << sh;
            OP_SRL:  res_d = bus.a >> sh;
            OP_SRA:  res_d = $signed(bus.a) >>> sh;
            default: res_d = '0;
        endcase
    end

    // One shift-add or restoring-divide step on the {acc_hi, acc_lo} pair
    logic [W:0]   madd;
    logic [W:0]   dtrial;
    logic [W-1:0] nxt_hi_d;
    logic [W-1:0] nxt_lo_d;

    always_comb begin
        madd   = {1'b0, acc_hi_q} +
                 (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        dtrial = {acc_hi_q, acc_lo_q[W-1]} - {1'b0, opnd_q};
        if (!is_div_q) begin
            nxt_hi_d = madd[W:1];
            nxt_lo_d = {madd[0], acc_lo_q[W-1:1]};
        end else if (!dtrial[W]) begin
            nxt_hi_d = dtrial[W-1:0];
            nxt_lo_d = {acc_lo_q[W-2:0], 1'b1};
        end else begin
            nxt_hi_d = {acc_hi_q[W-2:0], acc_lo_q[W-1]};
            nxt_lo_d = {acc_lo_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            count_q   <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            alu_out_q <= '0;
            hi_q      <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_ctl == OP_MULT) begin
                            state_q  <= ITER;
                            is_div_q <= 1'b0;
                            count_q  <= '0;
                            opnd_q   <= bus.a;
                            acc_hi_q <= '0;
                            acc_lo_q <= bus.b;
                        end else if (bus.alu_ctl == OP_DIV &&
                                     bus.b != '0) begin
                            state_q  <= ITER;
                            is_div_q <= 1'b1;
                            count_q  <= '0;
                            opnd_q   <= bus.b;
                            acc_hi_q <= '0;
                            acc_lo_q <= bus.a;
                        end else if (bus.alu_ctl == OP_DIV) begin
                            alu_out_q <= '1;
                            hi_q      <= bus.a;
                            ovf_q     <= 1'b0;
                            dz_q      <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            alu_out_q <= res_d;
                            hi_q      <= '0;
                            ovf_q     <= ovf_d;
                            dz_q      <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_hi_q <= nxt_hi_d;
                    acc_lo_q <= nxt_lo_d;
                    count_q  <= count_q + 1'b1;
                    if (count_q == SHW'(W-1)) begin
                        state_q   <= IDLE;
                        alu_out_q <= nxt_lo_d;
                        hi_q      <= nxt_hi_d;
                        ovf_q     <= 1'b0;
                        dz_q      <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q == ITER);
    assign bus.done     = done_q;
    assign bus.alu_out  = alu_out_q;
    assign bus.hi       = hi_q;
    assign bus.zero     = (alu_out_q == '0);
    assign bus.overflow = ovf_q;
    assign bus.div_zero = dz_q;
endmodule
